// File: rtl/fifo_rd_axis.sv
// fifo_rd_axis: read-side engine for the MAC TX FWFT FIFO.
// Pops whole, already-committed frames from the FIFO and presents them as
// AXI-Stream beats through a single output register, then enforces an
// inter-frame gap and reports the byte count of each completed frame.
//
// Handshake: a beat transfers on any rising edge where m_axis_tvalid and
// m_axis_tready are both high; once tvalid is raised the beat (tdata, tkeep,
// tlast) is held unchanged until it transfers, and tvalid never depends on
// tready. On the FIFO side, fifo_rd_en pops the word currently shown on
// fifo_rdata (first-word fall-through) and is only raised when !fifo_empty.
module fifo_rd_axis #(
    parameter int DATA_W     = 32,
    parameter int KEEP_W     = DATA_W / 8,
    parameter int MAX_FRAMES = 16,
    parameter int IFG_CYCLES = 3
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [DATA_W+KEEP_W:0]           fifo_rdata,
    input  logic                             fifo_empty,
    output logic                             fifo_rd_en,
    input  logic                             frame_commit,
    output logic [DATA_W-1:0]                m_axis_tdata,
    output logic [KEEP_W-1:0]                m_axis_tkeep,
    output logic                             m_axis_tlast,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic [$clog2(MAX_FRAMES+1)-1:0]  frames_pending,
    output logic                             frame_done,
    output logic [15:0]                      frame_bytes,
    output logic                             busy,
    output logic                             err_overflow,
    output logic                             err_underrun
);

    localparam int PW = $clog2(MAX_FRAMES + 1);
    // Gap counter is at least one bit wide even when no gap is configured.
    localparam int GW = $clog2(IFG_CYCLES + 2);
    localparam int WW = DATA_W + KEEP_W + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2,
        S_GAP    = 2'd3
    } state_t;

    state_t              state_q,  state_d;
    logic                tvalid_q, tvalid_d;
    logic [DATA_W-1:0]   tdata_q,  tdata_d;
    logic [KEEP_W-1:0]   tkeep_q,  tkeep_d;
    logic                tlast_q,  tlast_d;
    logic [PW-1:0]       pend_q,   pend_d;
    logic [15:0]         acc_q,    acc_d;
    logic [15:0]         fbytes_q, fbytes_d;
    logic                fdone_q,  fdone_d;
    logic [GW-1:0]       gap_q,    gap_d;
    logic                ovf_q,    ovf_d;
    logic                und_q,    und_d;

    logic                rd_last;
    logic [KEEP_W-1:0]   rd_keep;
    logic [DATA_W-1:0]   rd_data;
    logic                pop;
    logic                hs;
    logic [16:0]         beat_sum;
    logic [15:0]         beat_total;

    // Number of enabled bytes in a beat, widened so the add below can detect carry.
    function automatic logic [16:0] popcnt(input logic [KEEP_W-1:0] k);
        logic [16:0] cnt;
        cnt = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            cnt = cnt + {16'd0, k[i]};
        end
        return cnt;
    endfunction

    // Split the FWFT word and derive the pop / transfer strobes.
    always_comb begin
        rd_last    = fifo_rdata[WW-1];
        rd_keep    = fifo_rdata[DATA_W +: KEEP_W];
        rd_data    = fifo_rdata[DATA_W-1:0];
        pop        = (state_q == S_STREAM) && !fifo_empty && (!tvalid_q || m_axis_tready);
        hs         = tvalid_q && m_axis_tready;
        beat_sum   = {1'b0, acc_q} + popcnt(tkeep_q);
        beat_total = beat_sum[16] ? 16'hFFFF : beat_sum[15:0];
    end

    // Output register: load on pop, empty on a transfer without refill, else hold.
    always_comb begin
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        tkeep_d  = tkeep_q;
        tlast_d  = tlast_q;
        if (pop) begin
            tvalid_d = 1'b1;
            tdata_d  = rd_data;
            tkeep_d  = rd_keep;
            tlast_d  = rd_last;
        end else if (hs) begin
            tvalid_d = 1'b0;
        end
    end

    // Committed-frame counter; a commit that finds it full is flagged, not counted.
    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q;
        if (frame_commit && (pend_q == PW'(MAX_FRAMES))) begin
            ovf_d = 1'b1;
        end
        if (frame_commit && !(pop && rd_last)) begin
            if (pend_q != PW'(MAX_FRAMES)) begin
                pend_d = pend_q + PW'(1);
            end
        end else if (!frame_commit && pop && rd_last) begin
            pend_d = pend_q - PW'(1);
        end
    end

    // Frame sequencing: wait for a committed frame, stream it, drain the last beat, gap.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        und_d   = und_q;
        unique case (state_q)
            S_IDLE: begin
                if (pend_q != '0) begin
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                // The frame is fully buffered, so an empty FIFO here means the
                // writer broke the commit contract; flag it and keep waiting.
                if (fifo_empty) begin
                    und_d = 1'b1;
                end
                if (pop && rd_last) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (hs && tlast_q) begin
                    if (IFG_CYCLES > 0) begin
                        state_d = S_GAP;
                        gap_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                if (({1'b0, gap_q} + (GW+1)'(1)) >= (GW+1)'(IFG_CYCLES)) begin
                    state_d = S_IDLE;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Byte accounting: accumulate per transfer, publish and clear on the last beat.
    always_comb begin
        acc_d    = acc_q;
        fbytes_d = fbytes_q;
        fdone_d  = 1'b0;
        if (hs) begin
            if (tlast_q) begin
                fbytes_d = beat_total;
                acc_d    = '0;
                fdone_d  = 1'b1;
            end else begin
                acc_d = beat_total;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tlast_q  <= 1'b0;
            pend_q   <= '0;
            acc_q    <= '0;
            fbytes_q <= '0;
            fdone_q  <= 1'b0;
            gap_q    <= '0;
            ovf_q    <= 1'b0;
            und_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            tkeep_q  <= tkeep_d;
            tlast_q  <= tlast_d;
            pend_q   <= pend_d;
            acc_q    <= acc_d;
            fbytes_q <= fbytes_d;
            fdone_q  <= fdone_d;
            gap_q    <= gap_d;
            ovf_q    <= ovf_d;
            und_q    <= und_d;
        end
    end

    assign fifo_rd_en     = pop;
    assign m_axis_tdata   = tdata_q;
    assign m_axis_tkeep   = tkeep_q;
    assign m_axis_tlast   = tlast_q;
    assign m_axis_tvalid  = tvalid_q;
    assign frames_pending = pend_q;
    assign frame_done     = fdone_q;
    assign frame_bytes    = fbytes_q;
    assign busy           = (state_q != S_IDLE);
    assign err_overflow   = ovf_q;
    assign err_underrun   = und_q;

endmodule

// File: doc/fifo_rd_axis.md
Name: fifo_rd_axis

Overview:
- Read-side engine for the MAC TX path's FWFT synchronous FIFO.
- Drains whole frames from the FIFO's read port and emits them as AXI-Stream beats toward the MAC transmitter.
- Store-and-forward: a frame starts only after the write side commits it. The whole frame is therefore already buffered, so no mid-frame underrun is possible.
- Enforces a programmable inter-frame gap and reports per-frame byte counts.

Parameters:
- DATA_W, 32, stream data width in bits (multiple of 8).
- KEEP_W, DATA_W/8, byte-enable width.
- MAX_FRAMES, 16, maximum committed-but-unsent frames tracked.
- IFG_CYCLES, 3, idle cycles forced after a frame's last beat is accepted (0 = none).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- fifo_rdata  in  DATA_W+KEEP_W+1  FWFT word {last, keep, data}, valid whenever !fifo_empty.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  pop strobe.
- frame_commit  in  1  one-cycle pulse from the writer when a frame's last word has been written.
- m_axis_tdata  out  DATA_W  stream data.
- m_axis_tkeep  out  KEEP_W  byte enables.
- m_axis_tlast  out  1  end of frame.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  sink ready.
- frames_pending  out  $clog2(MAX_FRAMES+1)  committed frames not yet fully popped.
- frame_done  out  1  one-cycle pulse after a last-beat handshake.
- frame_bytes  out  16  byte count of the most recently completed frame.
- busy  out  1  FSM not in IDLE.
- err_overflow  out  1  sticky: commit received while frames_pending==MAX_FRAMES.
- err_underrun  out  1  sticky: fifo_empty seen in STREAM.

Behaviour:
- Reset (async assert, sync deassert by design): all outputs 0; FSM in IDLE; byte accumulator 0; gap counter 0.
- Output stage is a single register, tvalid/tdata/tkeep/tlast. Pop condition: fifo_rd_en = (state==STREAM) && !fifo_empty && (!m_axis_tvalid || m_axis_tready).
  - On a pop, the register loads fifo_rdata in that same clock edge and tvalid is set to 1.
  - When there is a handshake and no pop, tvalid is cleared to 0.
  - While tvalid=1 and tready=0, the register holds all fields stable (AXIS rule).
- frames_pending:
  - +1 on frame_commit; -1 on a pop whose last bit is 1; both in the same cycle leave it unchanged.
  - A commit at MAX_FRAMES holds the count and sets err_overflow.
  - A decrement at 0 cannot occur, because STREAM is entered only with frames_pending>0.
- FSM:
  - IDLE: if frames_pending>0, go to STREAM next cycle. No pop occurs in the IDLE cycle.
  - STREAM: pops per the pop condition. A pop with last=1 goes to DRAIN. If fifo_empty is seen in STREAM, set err_underrun and keep waiting.
  - DRAIN: no pops. On handshake with tlast=1: go to GAP if IFG_CYCLES>0, else IDLE.
  - GAP: count IFG_CYCLES cycles, then go to IDLE.
  - Minimum latency: commit at cycle 0 → frames_pending=1 at cycle 1 → STREAM at cycle 2 → first pop at cycle 2 → tvalid=1 at cycle 3.
- Byte accounting:
  - On each handshake, add popcount(tkeep) to the accumulator; saturate at 16'hFFFF.
  - On the last-beat handshake, frame_bytes takes the final total (accumulator + that beat) and frame_done pulses on the following cycle. The accumulator then clears.
  - frame_bytes holds until the next frame completes.
- busy = (state != IDLE).
- Reset mid-frame: output beat dropped (tvalid=0), counters cleared, and sticky errors cleared. FIFO contents are the writer's concern.

Test Plan:
- Single frame of 3 words, keep {F,F,3}; commit; tready=1 throughout → 3 beats on consecutive cycles, tlast on beat 3, frame_bytes=10, frame_done one cycle later, then busy held for 3 GAP cycles.
- Same frame with tready toggled 1,0,0,1,… → fifo_rd_en never asserted while tvalid=1 and tready=0; data stable across stalls; 3 beats total.
- Two frames committed back-to-back (2 and 1 words) → frames_pending reaches 2, then 1 after the first last-pop, then 0; at least 3 idle cycles (tvalid=0) between frame 1's tlast and frame 2's first beat.
- frame_commit in the same cycle as the pop of a last word, with frames_pending=1 → frames_pending stays 1 and the next frame starts after the gap.
- 17 commits with no draining and MAX_FRAMES=16 → frames_pending=16 and err_overflow=1 (sticky).
- rst_n low for 1 cycle mid-frame with tvalid=1 → tvalid, frames_pending, frame_bytes and busy all 0 immediately; the FSM restarts in IDLE.
